tinytpu_seq_ctrl: RTL and testbench
===================================

# tinytpu_seq_ctrl

Phase sequencer for the tinytpu N×N output-stationary systolic array. Counts serial operand bits arriving on the two input pins, then drives the skewed feed schedule into the array, triggers result capture and paces the serial result stream out. Sits between the top-level pin wrapper (`load_en`, `init`, `tx_ready`) and the operand shift registers, array and result serializer inside `tinytpu_top`.

## Interface
- `N`, 3: array dimension (N×N PEs).
- `D_W`, 8: operand width in bits.
- `R_W`, 16: result word width shifted out per PE.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset, applied as-is (no internal synchronizer in this block).
- `init`  in  1  synchronous soft restart; highest priority after reset.
- `load_en`  in  1  serial load qualifier; one operand bit per pin per cycle while high.
- `load_shift`  out  1  shift enable to the x/y operand shift registers.
- `acc_clr`  out  1  one-cycle clear of array accumulators.
- `feed_en`  out  1  array advance enable.
- `feed_step`  out  $clog2(3N-2)  skew index during compute, 0..3N-3.
- `res_capture`  out  1  one-cycle parallel load of the result serializer.
- `tx_shift`  out  1  serializer shift enable.
- `tx_ready`  out  1  `data_out_z` holds a valid result bit this cycle.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Constants: LOAD_BITS = N·N·D_W (72), FEED_CYCLES = 3N-2 (7), TX_BITS = N·N·R_W (144).
- One shared phase counter, width $clog2(max(LOAD_BITS, TX_BITS)+1), cleared on every state change.
- States: IDLE, LOAD, COMPUTE, CAPTURE, TX.
- IDLE: with `load_en`=1, accept bit 1, pulse `acc_clr` and go to LOAD with counter=1.
- LOAD: each cycle with `load_en`=1 accepts a bit and increments the counter. `load_en`=0 pauses: no shift and no timeout. Go to COMPUTE once bit LOAD_BITS has been accepted.
- COMPUTE: `feed_en`=1 and `feed_step`=counter for FEED_CYCLES cycles, then go to CAPTURE.
- CAPTURE: `res_capture`=1 for exactly one cycle, then go to TX.
- TX: `tx_shift`=`tx_ready`=1 for TX_BITS cycles (MSB-first order is owned by the serializer), then go to IDLE.
- `load_shift` = `load_en` AND state∈{IDLE, LOAD} AND NOT `init`. This is the only combinational output, so the bit is captured in the same cycle it is presented.
- `load_en` is ignored in COMPUTE, CAPTURE and TX. A host must not start the next job until `busy`=0.
- `init`=1 in any state: next state IDLE, counter=0, `acc_clr`=1 for that cycle, no shift, feed or capture. `init` and `load_en` together: `init` wins and the bit is dropped.
- All other outputs are Moore decodes of registered state and counter. `feed_step` is 0 outside COMPUTE.

## Timing
- Reset (async assert): state IDLE, counter 0. All outputs 0, including `feed_step`, except `load_shift`, which follows its equation.
- The first cycle after `rst_n` deasserts is IDLE and can accept a bit.
- Let T be the cycle in which bit LOAD_BITS is accepted. Then:
  - `feed_en` is high T+1..T+7, with `feed_step` running 0..6.
  - `res_capture` is high at T+8.
  - `tx_ready` is high T+9..T+152.
  - `busy` is 0 from T+153.
- End-to-end latency from last load bit to first result bit: 9 cycles.
- Counter never wraps: terminal compare at each phase limit, with a saturating guard.
- Reset mid-phase aborts immediately with no capture or TX pulses. Array and serializer contents are don't-care afterwards.

## Structure
- `tinytpu_pkg` holds the state enum, the LOAD_BITS/FEED_CYCLES/TX_BITS derivation functions and the counter width function, shared with `tinytpu_top` and the serializer.
- One sub-module, `tinytpu_phase_cnt`: a loadable up-counter with clear, enable and terminal-count compare. The FSM stays in `tinytpu_seq_ctrl`.

## Test plan
- Reset then 72 contiguous `load_en` cycles -> `acc_clr` at bit 1, `feed_en` for 7 cycles with `feed_step` 0..6, single `res_capture` at T+8, 144 `tx_ready` cycles, `busy` low at T+153.
- Load with `load_en` gaps (e.g. 10 cycles low after bit 30) -> exactly 72 `load_shift` pulses, and COMPUTE starts only after the 72nd.
- `init` asserted at COMPUTE `feed_step`=3 -> IDLE next cycle, `acc_clr`=1, no `res_capture`, `busy`=0.
- `init` and `load_en` both high in IDLE -> `load_shift`=0, state stays IDLE, `acc_clr`=1.
- `rst_n` pulsed low mid-TX (bit 50), asynchronously between edges -> outputs drop to 0 before the next edge, and a fresh 72-bit load completes normally.
- `load_en` held high during COMPUTE/TX -> no `load_shift`, and the schedule is unchanged.

Source files
------------

// File: rtl/tinytpu_pkg.sv
// Shared types and size derivations for the tinytpu sequencer, top and serializer.
package tinytpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_TX      = 3'd4
    } seq_state_t;

    function automatic int load_bits(input int n, input int dw);
        return n * n * dw;
    endfunction

    function automatic int feed_cycles(input int n);
        return 3 * n - 2;
    endfunction

    function automatic int tx_bits(input int n, input int rw);
        return n * n * rw;
    endfunction

    // One counter serves every phase, so it must hold the longest limit.
    function automatic int cnt_width(input int n, input int dw, input int rw);
        int m;
        m = (load_bits(n, dw) > tx_bits(n, rw)) ? load_bits(n, dw) : tx_bits(n, rw);
        return $clog2(m + 1);
    endfunction

    function automatic int step_width(input int n);
        return (feed_cycles(n) > 1) ? $clog2(feed_cycles(n)) : 1;
    endfunction

endpackage

// File: rtl/tinytpu_phase_cnt.sv
// Loadable up-counter with clear, enable and a terminal-count compare against a phase limit.
module tinytpu_phase_cnt #(
    parameter int CW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_en,
    input  logic [CW-1:0] i_limit,
    output logic [CW-1:0] o_count,
    output logic          o_tc
);

    logic [CW-1:0] r_cnt;

    // Saturating guard: the counter parks at all-ones rather than wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_count = r_cnt;
    assign o_tc    = (r_cnt == i_limit);

endmodule

// File: rtl/tinytpu_seq_ctrl.sv
// Phase sequencer: serial operand load, skewed feed, result capture and serial result pacing.
module tinytpu_seq_ctrl
    import tinytpu_pkg::*;
#(
    parameter int N   = 3,
    parameter int D_W = 8,
    parameter int R_W = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_init,
    input  logic                       i_load_en,
    output logic                       o_load_shift,
    output logic                       o_acc_clr,
    output logic                       o_feed_en,
    output logic [step_width(N)-1:0]   o_feed_step,
    output logic                       o_res_capture,
    output logic                       o_tx_shift,
    output logic                       o_tx_ready,
    output logic                       o_busy
);

    localparam int CW  = cnt_width(N, D_W, R_W);
    localparam int FSW = step_width(N);
    localparam logic [CW-1:0] LOAD_LIM = CW'(load_bits(N, D_W) - 1);
    localparam logic [CW-1:0] FEED_LIM = CW'(feed_cycles(N) - 1);
    localparam logic [CW-1:0] TX_LIM   = CW'(tx_bits(N, R_W) - 1);

    seq_state_t       r_state;
    logic             r_acc_clr;
    logic             r_feed_en;
    logic [FSW-1:0]   r_feed_step;
    logic             r_res_capture;
    logic             r_tx_active;
    logic             r_busy;

    logic             w_clr;
    logic             w_load;
    logic             w_en;
    logic [CW-1:0]    w_limit;
    logic [CW-1:0]    w_cnt;
    logic             w_tc;

    // Counter control: clear on every state change, preload 1 when the first bit lands.
    always_comb begin
        w_clr   = 1'b0;
        w_load  = 1'b0;
        w_en    = 1'b0;
        w_limit = '0;
        if (i_init) begin
            w_clr = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE:    w_load = i_load_en;
                ST_LOAD: begin
                    w_limit = LOAD_LIM;
                    w_clr   = i_load_en & w_tc;
                    w_en    = i_load_en & ~w_tc;
                end
                ST_COMPUTE: begin
                    w_limit = FEED_LIM;
                    w_clr   = w_tc;
                    w_en    = ~w_tc;
                end
                ST_CAPTURE: w_clr = 1'b1;
                ST_TX: begin
                    w_limit = TX_LIM;
                    w_clr   = w_tc;
                    w_en    = ~w_tc;
                end
                default:    w_clr = 1'b1;
            endcase
        end
    end

    tinytpu_phase_cnt #(.CW(CW)) u_phase_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (w_clr),
        .i_load     (w_load),
        .i_load_val (CW'(1)),
        .i_en       (w_en),
        .i_limit    (w_limit),
        .o_count    (w_cnt),
        .o_tc       (w_tc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_acc_clr     <= 1'b0;
            r_feed_en     <= 1'b0;
            r_feed_step   <= '0;
            r_res_capture <= 1'b0;
            r_tx_active   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_acc_clr     <= 1'b0;
            r_res_capture <= 1'b0;
            if (i_init) begin
                r_state     <= ST_IDLE;
                r_acc_clr   <= 1'b1;
                r_feed_en   <= 1'b0;
                r_feed_step <= '0;
                r_tx_active <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_load_en) begin
                            r_state   <= ST_LOAD;
                            r_acc_clr <= 1'b1;
                            r_busy    <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        if (i_load_en && w_tc) begin
                            r_state     <= ST_COMPUTE;
                            r_feed_en   <= 1'b1;
                            r_feed_step <= '0;
                        end
                    end
                    ST_COMPUTE: begin
                        if (w_tc) begin
                            r_state       <= ST_CAPTURE;
                            r_feed_en     <= 1'b0;
                            r_feed_step   <= '0;
                            r_res_capture <= 1'b1;
                        end else begin
                            r_feed_step <= FSW'(w_cnt + CW'(1));
                        end
                    end
                    ST_CAPTURE: begin
                        r_state     <= ST_TX;
                        r_tx_active <= 1'b1;
                    end
                    ST_TX: begin
                        if (w_tc) begin
                            r_state     <= ST_IDLE;
                            r_tx_active <= 1'b0;
                            r_busy      <= 1'b0;
                        end
                    end
                    default: begin
                        r_state     <= ST_IDLE;
                        r_feed_en   <= 1'b0;
                        r_feed_step <= '0;
                        r_tx_active <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_load_shift  = i_load_en & ~i_init & ((r_state == ST_IDLE) | (r_state == ST_LOAD));
    assign o_acc_clr     = r_acc_clr;
    assign o_feed_en     = r_feed_en;
    assign o_feed_step   = r_feed_step;
    assign o_res_capture = r_res_capture;
    assign o_tx_shift    = r_tx_active;
    assign o_tx_ready    = r_tx_active;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_tinytpu_seq_ctrl.sv
// Self-checking bench for tinytpu_seq_ctrl: timeline-offset reference model plus literal pins.
module tb_tinytpu_seq_ctrl;

    localparam int N   = 3;
    localparam int D_W = 8;
    localparam int R_W = 16;
    localparam int LB  = N * N * D_W;
    localparam int FC  = 3 * N - 2;
    localparam int TXB = N * N * R_W;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       init = 1'b0;
    logic       load_en = 1'b0;
    logic       load_shift, acc_clr, feed_en, res_capture, tx_shift, tx_ready, busy;
    logic [2:0] feed_step;

    tinytpu_seq_ctrl #(.N(N), .D_W(D_W), .R_W(R_W)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_init        (init),
        .i_load_en     (load_en),
        .o_load_shift  (load_shift),
        .o_acc_clr     (acc_clr),
        .o_feed_en     (feed_en),
        .o_feed_step   (feed_step),
        .o_res_capture (res_capture),
        .o_tx_shift    (tx_shift),
        .o_tx_ready    (tx_ready),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: bits accepted so far and the cycle of the last load bit.
    int cyc = 0;
    int bits = 0;
    int tLast = -1;
    bit accPend = 1'b0;

    // Observations for literal pins.
    int tRec = 0;
    int cntFeed, cntCap, cntTx, cntLs, firstTx, firstFeed, idleAt;
    int obsStep, obsLs, obsAcc, obsBusy;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic bit jobActive();
        return (tLast >= 0) && ((cyc - tLast) <= FC + 1 + TXB);
    endfunction

    task automatic clearCounts();
        cntFeed = 0; cntCap = 0; cntTx = 0; cntLs = 0;
        firstTx = -1; firstFeed = -1; idleAt = -1;
    endtask

    task automatic modelReset();
        bits = 0; tLast = -1; accPend = 1'b0;
    endtask

    task automatic checkOutput(input bit le, input bit in);
        int d;
        bit eFeed, eCap, eTx;
        d     = jobActive() ? (cyc - tLast) : -1;
        eFeed = (d >= 1) && (d <= FC);
        eCap  = (d == FC + 1);
        eTx   = (d >= FC + 2) && (d <= FC + 1 + TXB);
        chk("load_shift", int'(load_shift), int'(le && !in && d < 0));
        chk("acc_clr", int'(acc_clr), int'(accPend));
        chk("feed_en", int'(feed_en), int'(eFeed));
        chk("feed_step", int'(feed_step), eFeed ? d - 1 : 0);
        chk("res_capture", int'(res_capture), int'(eCap));
        chk("tx_shift", int'(tx_shift), int'(eTx));
        chk("tx_ready", int'(tx_ready), int'(eTx));
        chk("busy", int'(busy), int'((d >= 1) || (bits > 0)));
        obsStep = int'(feed_step); obsLs = int'(load_shift);
        obsAcc = int'(acc_clr); obsBusy = int'(busy);
        cntFeed += int'(feed_en); cntCap += int'(res_capture);
        cntTx += int'(tx_ready); cntLs += int'(load_shift);
        if (feed_en && firstFeed < 0) firstFeed = cyc;
        if (tx_ready && firstTx < 0 && cyc > tRec) firstTx = cyc;
        if (!busy && idleAt < 0 && cyc > tRec) idleAt = cyc;
    endtask

    task automatic modelStep(input bit le, input bit in);
        bit act;
        act = jobActive();
        accPend = 1'b0;
        if (in) begin
            bits = 0; tLast = -1; accPend = 1'b1;
        end else if (!act && le) begin
            if (bits == 0) accPend = 1'b1;
            bits++;
            if (bits == LB) begin
                tLast = cyc;
                bits  = 0;
            end
        end
        cyc++;
    endtask

    task automatic applyStimulus(input bit le, input bit in);
        @(negedge clk);
        load_en = le;
        init    = in;
        #1;
        checkOutput(le, in);
        @(posedge clk);
        modelStep(le, in);
    endtask

    task automatic loadBits(input int n, input int gapAfter, input int gapLen);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0);
            if (i + 1 == gapAfter) repeat (gapLen) applyStimulus(1'b0, 1'b0);
        end
        tRec = cyc - 1;
    endtask

    // mode 0: load_en low, 1: held high, 2: random while the job runs.
    task automatic waitIdle(input int mode, input int budget);
        bit done;
        bit le;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            if (jobActive()) le = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            else le = (bits > 0);
            applyStimulus(le, 1'b0);
            if (obsBusy == 0) done = 1'b1;
        end
        if (!done) chk("idle_timeout", 0, 1);
    endtask

    task automatic asyncReset();
        #2;
        rst_n = 1'b0; load_en = 1'b0; init = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_tx_ready", int'(tx_ready), 0);
        chk("rst_feed", int'(feed_en) + int'(feed_step) + int'(res_capture) + int'(acc_clr), 0);
        chk("rst_load_shift", int'(load_shift), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
    endtask

    initial begin
        clearCounts();
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_outputs", int'(acc_clr) + int'(feed_en) + int'(feed_step) + int'(res_capture)
            + int'(tx_shift) + int'(tx_ready) + int'(load_shift), 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] contiguous load, load_en held through compute/tx");
        clearCounts();
        loadBits(LB, 0, 0);
        waitIdle(1, 400);
        chk("lit_feed_cycles", cntFeed, 7);
        chk("lit_captures", cntCap, 1);
        chk("lit_tx_cycles", cntTx, 144);
        chk("lit_first_feed", firstFeed - tRec, 1);
        chk("lit_latency", firstTx - tRec, 9);
        chk("lit_idle_at", idleAt - tRec, 153);
        chk("lit_load_pulses", cntLs, 72);

        $display("[TB] gapped load");
        clearCounts();
        loadBits(LB, 30, 10);
        chk("lit_gap_load_pulses", cntLs, 72);
        waitIdle(0, 400);
        chk("lit_gap_first_feed", firstFeed - tRec, 1);

        $display("[TB] init during compute");
        clearCounts();
        loadBits(LB, 0, 0);
        repeat (3) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        chk("lit_step_at_init", obsStep, 3);
        applyStimulus(1'b0, 1'b0);
        chk("lit_init_acc_clr", obsAcc, 1);
        chk("lit_init_busy", obsBusy, 0);
        repeat (12) applyStimulus(1'b0, 1'b0);
        chk("lit_no_capture", cntCap, 0);

        $display("[TB] init with load_en in idle");
        applyStimulus(1'b1, 1'b1);
        chk("lit_init_wins", obsLs, 0);
        applyStimulus(1'b0, 1'b0);
        chk("lit_idle_acc_clr", obsAcc, 1);
        chk("lit_idle_busy", obsBusy, 0);

        $display("[TB] async reset mid-tx");
        loadBits(LB, 0, 0);
        repeat (FC + 1 + 50) applyStimulus(1'b0, 1'b0);
        #2;
        chk("lit_tx_before_reset", int'(tx_ready), 1);
        asyncReset();
        clearCounts();
        loadBits(LB, 0, 0);
        waitIdle(0, 400);
        chk("lit_after_reset_tx", cntTx, 144);
        chk("lit_after_reset_cap", cntCap, 1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0));
        end
        waitIdle(2, 400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
